// File: rtl/unibus_int_arb.sv
// unibus_int_arb
//
// Interrupt arbiter for the iopage device set. Each device raises a
// level-sensitive request with its own bus-request level and vector; the
// arbiter picks one eligible winner against the current CPU priority,
// presents a single interrupt/vector pair to the CPU and, once the CPU takes
// it, returns a one-cycle acknowledge to the granted device so it can clear
// its request.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset       synchronous active-low reset
//   dev_irq     per-device request, held by the device until dev_ack
//   dev_level   per-device BR level, device i at [3i+2:3i], 0 = disabled
//   dev_vector  per-device vector, device i at [8i+7:8i]
//   cpu_ipl     current CPU priority
//   cpu_ack     one-cycle pulse: CPU has taken the presented interrupt
//   interrupt   interrupt pending to the CPU
//   vector      vector of the granted device, valid while interrupt=1
//   dev_ack     one-hot, one-cycle acknowledge to the granted device
//   grant_id    index of the granted device, valid while interrupt=1
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | arbitrating; latches the winner when any device is eligible
// PRESENT | interrupt/vector presented to CPU, waiting for cpu_ack
// ACK     | dev_ack pulsed to the granted device
// HOLDOFF | one quiet cycle so the device can drop its request

module unibus_int_arb #(
  parameter int N_DEV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DEV-1:0]     dev_irq,
  input  logic [3*N_DEV-1:0]   dev_level,
  input  logic [8*N_DEV-1:0]   dev_vector,
  input  logic [2:0]           cpu_ipl,
  input  logic                 cpu_ack,
  output logic                 interrupt,
  output logic [7:0]           vector,
  output logic [N_DEV-1:0]     dev_ack,
  output logic [2:0]           grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ACK     = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] grant_level;

  logic       any_elig;
  logic [2:0] win_idx;
  logic [2:0] win_level;
  logic [7:0] win_vector;

  // Winner: highest level among eligible devices. The strict compare keeps
  // the first (lowest-index) device on a tie.
  always_comb begin
    any_elig   = 1'b0;
    win_idx    = '0;
    win_level  = '0;
    win_vector = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_irq[i] && (dev_level[3*i +: 3] > cpu_ipl)) begin
        if (!any_elig || (dev_level[3*i +: 3] > win_level)) begin
          any_elig   = 1'b1;
          win_idx    = 3'(i);
          win_level  = dev_level[3*i +: 3];
          win_vector = dev_vector[8*i +: 8];
        end
      end
    end
  end

  // Request line of the latched device and its one-hot acknowledge. Built by
  // compare rather than indexing so grant_id never selects past N_DEV.
  logic             granted_irq;
  logic [N_DEV-1:0] ack_onehot;

  always_comb begin
    granted_irq = 1'b0;
    ack_onehot  = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (grant_id == 3'(i)) begin
        granted_irq   = dev_irq[i];
        ack_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      interrupt   <= 1'b0;
      vector      <= '0;
      dev_ack     <= '0;
      grant_id    <= '0;
      grant_level <= '0;
    end else begin
      dev_ack <= '0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            state       <= PRESENT;
            interrupt   <= 1'b1;
            grant_id    <= win_idx;
            vector      <= win_vector;
            grant_level <= win_level;
          end
        end
        PRESENT: begin
          // cpu_ack has priority over a simultaneous withdraw or IPL raise:
          // the CPU has already committed to this vector.
          if (cpu_ack) begin
            state     <= ACK;
            interrupt <= 1'b0;
            dev_ack   <= ack_onehot;
          end else if (!granted_irq || (cpu_ipl >= grant_level)) begin
            state     <= IDLE;
            interrupt <= 1'b0;
          end
        end
        ACK: begin
          state <= HOLDOFF;
        end
        HOLDOFF: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule
